// File: rtl/gate_result_checker_if.sv
// Bundles the result-capture, UART-byte and status signals of the gate result checker.
// master = the capture stage / UART / board side, slave = the checker itself.
// Counter width follows CNT_W and must match the checker instance.
interface gate_result_checker_if #(
  parameter int CNT_W = 8
);
  logic             result_valid;
  logic [3:0]       result_bits;
  logic [3:0]       expected_tt;
  logic             clr_counts;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [2:0]       gate_id;
  logic [7:0]       led;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             overrun;

  modport master (
    output result_valid, result_bits, expected_tt, clr_counts, tx_done,
    input  tx_start, tx_data, busy, pass, fail, gate_id, led,
           pass_count, fail_count, overrun
  );

  modport slave (
    input  result_valid, result_bits, expected_tt, clr_counts, tx_done,
    output tx_start, tx_data, busy, pass, fail, gate_id, led,
           pass_count, fail_count, overrun
  );
endinterface

// File: rtl/gate_result_checker.sv
// Compares a 4-vector capture with its truth table, classifies the gate, counts, reports over UART.
// Latency: busy one cycle after result_valid, verdict and first tx_start two cycles after it.
// Backpressure: one report in flight; result_valid while busy is dropped and flagged in overrun.
module gate_result_checker #(
  parameter logic [7:0] REPORT_HDR = 8'hA5,
  parameter int         CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_result_checker_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_SEND, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [3:0]       rb_q, rb_d;
  logic [3:0]       et_q, et_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [2:0]       gate_id_q, gate_id_d;
  logic [7:0]       led_q, led_d;
  logic [CNT_W-1:0] pass_count_q, pass_count_d;
  logic [CNT_W-1:0] fail_count_q, fail_count_d;
  logic             overrun_q, overrun_d;

  function automatic logic [2:0] classify(input logic [3:0] tt);
    case (tt)
      4'b1000: classify = 3'd1;
      4'b1110: classify = 3'd2;
      4'b0111: classify = 3'd3;
      4'b0001: classify = 3'd4;
      4'b0110: classify = 3'd5;
      4'b1001: classify = 3'd6;
      default: classify = 3'd0;
    endcase
  endfunction

  // Next-state and output computation. The first byte's tx_start is launched from COMPARE so it
  // appears two cycles after result_valid; later bytes are launched from SEND (two cycles after tx_done).
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    rb_d         = rb_q;
    et_d         = et_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    gate_id_d    = gate_id_q;
    led_d        = led_q;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    overrun_d    = overrun_q;

    if (bus.result_valid && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.result_valid) begin
          rb_d    = bus.result_bits;
          et_d    = bus.expected_tt;
          busy_d  = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass_d    = (rb_q == et_q);
        fail_d    = (rb_q != et_q);
        gate_id_d = classify(rb_q);
        led_d     = {pass_d, fail_d, gate_id_d, rb_q[2:0]};
        if (pass_d) begin
          if (pass_count_q != {CNT_W{1'b1}}) pass_count_d = pass_count_q + CNT_W'(1);
        end else begin
          if (fail_count_q != {CNT_W{1'b1}}) fail_count_d = fail_count_q + CNT_W'(1);
        end
        k_d        = 2'd0;
        tx_start_d = 1'b1;
        tx_data_d  = REPORT_HDR;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        // Header already went out on the COMPARE exit; only bytes 1 and 2 launch here.
        if (k_q != 2'd0) begin
          tx_start_d = 1'b1;
          case (k_q)
            2'd1:    tx_data_d = {pass_q, gate_id_q, rb_q};
            2'd2:    tx_data_d = {4'h0, et_q};
            default: tx_data_d = REPORT_HDR;
          endcase
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          if (k_q == 2'd2) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.clr_counts) begin
      pass_count_d = '0;
      fail_count_d = '0;
      overrun_d    = 1'b0;
    end
  end

  // State and output registers; reset aborts any report in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      rb_q         <= 4'h0;
      et_q         <= 4'h0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      gate_id_q    <= 3'd0;
      led_q        <= 8'h00;
      pass_count_q <= '0;
      fail_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rb_q         <= rb_d;
      et_q         <= et_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      gate_id_q    <= gate_id_d;
      led_q        <= led_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.gate_id    = gate_id_q;
  assign bus.led        = led_q;
  assign bus.pass_count = pass_count_q;
  assign bus.fail_count = fail_count_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/gate_result_checker.md
# gate_result_checker

Downstream of the DUT stimulus/capture stage in the mini gate tester. Takes each completed 4-vector capture of a 2-input DUT and compares it against the expected truth table. It classifies the observed function as a standard gate, keeps running pass/fail counts, drives the board LEDs, and streams a 3-byte report to the UART transmitter.

## Interface
Parameters:
- REPORT_HDR, 8'hA5, first byte of every UART report
- CNT_W, 8, width of pass/fail counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- result_valid  in  1  one-cycle pulse: result_bits/expected_tt valid this cycle
- result_bits  in  4  captured DUT outputs; bit i = output for input pair i (bit1=A, bit0=B)
- expected_tt  in  4  expected truth table, same bit order
- clr_counts  in  1  one-cycle pulse: zero counters and overrun flag
- tx_start  out  1  one-cycle pulse: UART transmitter loads tx_data
- tx_data  out  8  report byte
- tx_done  in  1  one-cycle pulse from UART transmitter: byte finished
- busy  out  1  high from capture until the last report byte's tx_done
- pass  out  1  last verdict: result_bits == expected_tt
- fail  out  1  last verdict: mismatch; pass and fail are never both high
- gate_id  out  3  0 unknown, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR; 7 never driven
- led  out  8  {pass, fail, gate_id[2:0] ... } (see Operation)
- pass_count  out  CNT_W  saturating count of passing runs
- fail_count  out  CNT_W  saturating count of failing runs
- overrun  out  1  sticky: result_valid arrived while busy

## Operation
- FSM states: IDLE, COMPARE, SEND, WAIT. Byte index k is 2 bits.
- IDLE: on result_valid, register result_bits and expected_tt, set busy, go to COMPARE.
- COMPARE (1 cycle):
  - Update pass/fail and gate_id.
  - Increment the matching counter, unless it is already at all-ones, in which case it holds.
  - Set k=0 and go to SEND.
- Classification, keyed on result_bits:
  - 4'b1000 → 1 (AND)
  - 4'b1110 → 2 (OR)
  - 4'b0111 → 3 (NAND)
  - 4'b0001 → 4 (NOR)
  - 4'b0110 → 5 (XOR)
  - 4'b1001 → 6 (XNOR)
  - anything else → 0 (unknown)
- SEND: drive tx_data = byte k, pulse tx_start for one cycle, then go to WAIT.
  - Byte 0 = REPORT_HDR.
  - Byte 1 = {pass, gate_id, result_bits}.
  - Byte 2 = {4'h0, expected_tt}.
- WAIT: hold tx_data. On tx_done: if k==2, clear busy and go to IDLE; otherwise increment k and go to SEND. tx_done seen in any other state is ignored.
- led = {pass, fail, gate_id, result_bits[2:0]}, from registered values.
- result_valid in any state other than IDLE: the data is dropped and overrun is set. The FSM is not disturbed.
- clr_counts:
  - Zeroes pass_count, fail_count and overrun next cycle, from any state. It has priority over a same-cycle increment.
  - It does not affect pass, fail, gate_id, led or an in-flight report.
- Reset values (rst_n low), applied immediately, even mid-report:
  - state IDLE, k 0.
  - tx_start 0, tx_data 8'h00, busy 0.
  - pass 0, fail 0, gate_id 0, led 8'h00.
  - Both counters 0, overrun 0.
  - No partial report resumes after reset release.

## Timing
- result_valid at cycle N:
  - busy high at N+1.
  - pass/fail/gate_id/led/counters updated at N+2 (registered at end of COMPARE).
  - First tx_start at N+2.
- tx_start is high for exactly one cycle per byte. A tx_done at cycle M gives the next tx_start at M+2 (WAIT→SEND, SEND asserts).
- busy drops one cycle after the third tx_done. A result_valid in that same following cycle is accepted.
- Minimum back-to-back report spacing is set by the UART. The checker adds 2 cycles per byte.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-report:
  - Stimulus: pulse rst_n low after byte 1's tx_start.
  - Required: all outputs return to their reset values, no further tx_start occurs, and a new result_valid works normally.
- Correct AND:
  - Stimulus: result_bits=4'b1000, expected_tt=4'b1000, each tx_done returned 5 cycles after its tx_start.
  - Required: pass=1, gate_id=1, led=8'b1000_1000, pass_count=1.
  - Required tx_data sequence: A5, 98, 08.
  - Required: busy clears after the third tx_done.
- Mismatch, unknown gate:
  - Stimulus: result_bits=4'b0011, expected_tt=4'b0110.
  - Required: fail=1, gate_id=0, fail_count=1.
  - Required bytes: A5, 03, 06.
- Overrun:
  - Stimulus: second result_valid while in WAIT.
  - Required: overrun=1, report bytes unchanged, counters incremented once only.
  - Then pulse clr_counts. Required: counters=0 and overrun=0 next cycle.
- Saturation:
  - Stimulus: 256 passing runs.
  - Required: pass_count stays at 8'hFF, fail_count stays 0.
  - Then a clr_counts in the same cycle as COMPARE. Required: count reads 0.
